seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 96 +++++++++
 tb/tb_seq_multiplier.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Unsigned N x N shift-and-add multiplier with a 4-phase
//               req/ready handshake; one multiplier bit per BUSY cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [N-1:0]     Multiplicand,
    input  logic [N-1:0]     Multiplier,
    output logic [2*N-1:0]   P,
    output logic             ready,
    output logic             busy
);

    localparam int         c_CNT_W = $clog2(N + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [2*N-1:0]     r_a;
    logic [N-1:0]       r_b;
    logic [2*N-1:0]     r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*N-1:0]     r_p;
    logic               r_ready;
    logic               r_busy;

    logic [2*N-1:0]     w_sum;

    // r_a already holds A shifted by the current iteration index
    assign w_sum = r_acc + (r_b[0] ? r_a : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req) begin
                        r_a     <= {{N{1'b0}}, Multiplicand};
                        r_b     <= Multiplier;
                        r_acc   <= '0;
                        r_cnt   <= c_CNT_W'(N);
                        r_busy  <= 1'b1;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    // N iteration edges, then one edge publishing the result
                    if (r_cnt != '0) begin
                        r_acc <= w_sum;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        r_p     <= r_acc;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (!req) begin
                        r_ready <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign P     = r_p;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier (directed table,
//               reset/handshake corner sequences, randomized operands).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int c_N   = 16;
    localparam int c_LAT = c_N + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                req;
    logic [c_N-1:0]      Multiplicand;
    logic [c_N-1:0]      Multiplier;
    logic [2*c_N-1:0]    P;
    logic                ready;
    logic                busy;

    int n_pass  = 0;
    int n_total = 0;
    int edges   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs [8];

    seq_multiplier #(.N(c_N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .P            (P),
        .ready        (ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // one clock edge, sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        edges++;
        check("busy_ready_exclusive", {63'b0, busy & ready}, 64'd0);
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        Multiplicand = a;
        Multiplier   = b;
        req          = 1'b1;
        step();
        edges = 0;
        check("accept_busy", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_done(input logic [31:0] exp, input bit scramble);
        while (!ready && edges < 40) begin
            if (scramble) begin
                @(negedge clk);
                Multiplicand = 16'($urandom);
                Multiplier   = 16'($urandom);
            end
            if (edges == c_LAT - 1) check("ready_not_early", {63'b0, ready}, 64'd0);
            step();
        end
        check("latency", 64'(edges), 64'(c_LAT));
        check("product", {32'b0, P}, {32'b0, exp});
    endtask

    task automatic release_req(input logic [31:0] exp);
        @(negedge clk);
        req = 1'b0;
        step();
        check("ready_cleared", {63'b0, ready}, 64'd0);
        check("p_retained", {32'b0, P}, {32'b0, exp});
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    initial begin
        vecs[0] = '{16'd65000,  16'd6700,   32'd435500000};
        vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
        vecs[2] = '{16'd0,      16'd12345,  32'd0};
        vecs[3] = '{16'd12345,  16'd0,      32'd0};
        vecs[4] = '{16'd1,      16'd1,      32'd1};
        vecs[5] = '{16'd300,    16'd200,    32'd60000};
        vecs[6] = '{16'h8000,   16'd2,      32'h00010000};
        vecs[7] = '{16'd7,      16'd9,      32'd63};

        rst = 1'b1; req = 1'b0; Multiplicand = '0; Multiplier = '0;
        step();
        step();
        check("rst_P", {32'b0, P}, 64'd0);
        check("rst_ready", {63'b0, ready}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);

        // req already high on the first edge with rst low must be accepted
        @(negedge clk);
        Multiplicand = 16'd11; Multiplier = 16'd13; req = 1'b1; rst = 1'b0;
        step();
        edges = 0;
        check("accept_after_rst", {63'b0, busy}, 64'd1);
        wait_done(32'd143, 1'b0);
        release_req(32'd143);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(vecs[i].p, 1'b0);
            release_req(vecs[i].p);
        end

        // reset in the middle of BUSY discards the operation
        start_op(16'd300, 16'd200);
        for (int i = 0; i < 7; i++) step();
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        step();
        check("midbusy_rst_P", {32'b0, P}, 64'd0);
        check("midbusy_rst_ready", {63'b0, ready}, 64'd0);
        check("midbusy_rst_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_op(16'd7, 16'd9);
        wait_done(32'd63, 1'b0);
        release_req(32'd63);

        // operand changes and req pulse while BUSY are ignored
        start_op(16'd1000, 16'd2000);
        step();
        step();
        @(negedge clk);
        Multiplicand = 16'd1; Multiplier = 16'd1; req = 1'b0;
        step();
        @(negedge clk);
        req = 1'b1;
        step();
        wait_done(32'd2000000, 1'b0);

        // req held through DONE must not restart
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            Multiplicand = 16'($urandom);
            Multiplier   = 16'($urandom);
            step();
            check("hold_ready", {63'b0, ready}, 64'd1);
            check("hold_busy", {63'b0, busy}, 64'd0);
            check("hold_P", {32'b0, P}, 64'd2000000);
        end
        release_req(32'd2000000);
        start_op(16'd3, 16'd5);
        wait_done(32'd15, 1'b0);
        release_req(32'd15);

        // randomized operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            logic [15:0] a, b;
            logic [31:0] e;
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 8 == 0) a = '0;
            if (i % 8 == 1) b = 16'hFFFF;
            e = model(a, b);
            start_op(a, b);
            wait_done(e, i[0]);
            release_req(e);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
